fetch_redirect_ctrl: RTL and testbench

FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

---
 rtl/fetch_redirect_ctrl_pkg.sv | 18 +
 rtl/fetch_redirect_ctrl_if.sv | 32 +++
 rtl/fetch_redirect_prio.sv | 32 +++
 rtl/fetch_redirect_ctrl.sv | 94 +++++++++
 tb/tb_fetch_redirect_ctrl.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fetch_redirect_ctrl_pkg.sv
// rtl/fetch_redirect_ctrl_pkg.sv - shared widths, redirect source ids and drain FSM states
package fetch_redirect_ctrl_pkg;

  localparam int IF_PC_W       = 32;
  localparam int MAX_OUTST_DEF = 3;

  typedef enum logic [1:0] {
    SRC_ID = 2'd0,
    SRC_EX = 2'd1,
    SRC_WB = 2'd2
  } redir_src_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - redirect sources, icache handshake and fetch control bundle
interface fetch_redirect_ctrl_if;
  import fetch_redirect_ctrl_pkg::*;

  logic               wb_redir_valid;
  logic [IF_PC_W-1:0] wb_redir_pc;
  logic               ex_redir_valid;
  logic [IF_PC_W-1:0] ex_redir_pc;
  logic               id_redir_valid;
  logic [IF_PC_W-1:0] id_redir_pc;
  logic               req_fire;
  logic               resp_valid;
  logic               need_jump;
  logic [IF_PC_W-1:0] jump_pc;
  logic               flush_IF;
  logic               flush_ID;
  logic               resp_discard;
  logic               issue_stall;
  logic               draining;

  modport master (
    output wb_redir_valid, wb_redir_pc, ex_redir_valid, ex_redir_pc,
    output id_redir_valid, id_redir_pc, req_fire, resp_valid,
    input  need_jump, jump_pc, flush_IF, flush_ID, resp_discard, issue_stall, draining
  );

  modport slave (
    input  wb_redir_valid, wb_redir_pc, ex_redir_valid, ex_redir_pc,
    input  id_redir_valid, id_redir_pc, req_fire, resp_valid,
    output need_jump, jump_pc, flush_IF, flush_ID, resp_discard, issue_stall, draining
  );
endinterface

// File: rtl/fetch_redirect_prio.sv
// rtl/fetch_redirect_prio.sv - fixed-priority redirect select, WB over EX over ID
module fetch_redirect_prio
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic               i_wb_valid,
  input  logic [IF_PC_W-1:0] i_wb_pc,
  input  logic               i_ex_valid,
  input  logic [IF_PC_W-1:0] i_ex_pc,
  input  logic               i_id_valid,
  input  logic [IF_PC_W-1:0] i_id_pc,
  output logic               o_need_jump,
  output logic [IF_PC_W-1:0] o_jump_pc,
  output redir_src_e         o_src
);

  always_comb begin
    o_need_jump = i_wb_valid | i_ex_valid | i_id_valid;
    o_jump_pc   = '0;
    o_src       = SRC_ID;
    if (i_wb_valid) begin
      o_jump_pc = i_wb_pc;
      o_src     = SRC_WB;
    end else if (i_ex_valid) begin
      o_jump_pc = i_ex_pc;
      o_src     = SRC_EX;
    end else if (i_id_valid) begin
      o_jump_pc = i_id_pc;
      o_src     = SRC_ID;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch redirect arbitration with stale icache response drain
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_redirect_ctrl_if.slave  bus
);

  localparam int            CW      = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

  logic               w_need_jump;
  logic [IF_PC_W-1:0] w_jump_pc;
  redir_src_e         w_src;
  logic               w_resp_eff;
  logic [CW-1:0]      w_disc_load;
  logic [CW-1:0]      w_outst_nxt;
  logic [CW-1:0]      w_disc_nxt;
  logic [CW-1:0]      r_outst;
  logic [CW-1:0]      r_disc;
  drain_state_e       r_state;
  drain_state_e       w_state_nxt;

  fetch_redirect_prio u_prio (
    .i_wb_valid  (bus.wb_redir_valid),
    .i_wb_pc     (bus.wb_redir_pc),
    .i_ex_valid  (bus.ex_redir_valid),
    .i_ex_pc     (bus.ex_redir_pc),
    .i_id_valid  (bus.id_redir_valid),
    .i_id_pc     (bus.id_redir_pc),
    .o_need_jump (w_need_jump),
    .o_jump_pc   (w_jump_pc),
    .o_src       (w_src)
  );

  // a response with nothing in flight is spurious and must not move the counters
  assign w_resp_eff  = bus.resp_valid && (r_outst != '0);
  assign w_disc_load = r_outst + CW'(bus.req_fire) - CW'(w_resp_eff);

  always_comb begin
    w_outst_nxt = r_outst;
    case ({bus.req_fire, w_resp_eff})
      2'b10:   w_outst_nxt = r_outst + CW'(1);
      2'b01:   w_outst_nxt = r_outst - CW'(1);
      default: w_outst_nxt = r_outst;
    endcase
  end

  always_comb begin
    w_disc_nxt = r_disc;
    if (w_need_jump) begin
      w_disc_nxt = w_disc_load;
    end else if (w_resp_eff && (r_disc != '0)) begin
      w_disc_nxt = r_disc - CW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_need_jump && (w_disc_load != '0)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_disc_nxt == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outst <= '0;
      r_disc  <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_outst <= w_outst_nxt;
      r_disc  <= w_disc_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign bus.need_jump    = w_need_jump;
  assign bus.jump_pc      = w_jump_pc;
  assign bus.flush_IF     = w_need_jump;
  assign bus.flush_ID     = w_need_jump && (w_src != SRC_ID);
  assign bus.resp_discard = !rst && bus.resp_valid && (w_need_jump || (r_disc != '0));
  assign bus.issue_stall  = (r_outst == MAX_CNT) && !bus.resp_valid;
  assign bus.draining     = (r_state == ST_DRAIN);

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - scoreboard bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

  typedef struct {
    logic        nj;
    logic [31:0] jpc;
    logic        fif;
    logic        fid;
    logic        dis;
    logic        stall;
    logic        drn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  logic        n_rst = 1'b0;
  logic        n_wbv = 1'b0, n_exv = 1'b0, n_idv = 1'b0;
  logic [31:0] n_wbpc = '0, n_expc = '0, n_idpc = '0;

  fetch_redirect_ctrl_if bus();

  fetch_redirect_ctrl #(.MAX_OUTST(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t E(logic nj, logic [31:0] jpc, logic fif, logic fid,
                             logic dis, logic stall, logic drn);
    exp_t e;
    e.nj = nj; e.jpc = jpc; e.fif = fif; e.fid = fid;
    e.dis = dis; e.stall = stall; e.drn = drn;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rf, input logic rv, input exp_t e);
    @(posedge clk);
    #1;
    rst                = n_rst;
    bus.wb_redir_valid = n_wbv;  bus.wb_redir_pc = n_wbpc;
    bus.ex_redir_valid = n_exv;  bus.ex_redir_pc = n_expc;
    bus.id_redir_valid = n_idv;  bus.id_redir_pc = n_idpc;
    bus.req_fire       = rf;
    bus.resp_valid     = rv;
    n_rst = 1'b0; n_wbv = 1'b0; n_exv = 1'b0; n_idv = 1'b0;
    n_wbpc = '0;  n_expc = '0;  n_idpc = '0;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("need_jump",    {31'b0, bus.need_jump},    {31'b0, e.nj});
      chk("jump_pc",      bus.jump_pc,               e.jpc);
      chk("flush_IF",     {31'b0, bus.flush_IF},     {31'b0, e.fif});
      chk("flush_ID",     {31'b0, bus.flush_ID},     {31'b0, e.fid});
      chk("resp_discard", {31'b0, bus.resp_discard}, {31'b0, e.dis});
      chk("issue_stall",  {31'b0, bus.issue_stall},  {31'b0, e.stall});
      chk("draining",     {31'b0, bus.draining},     {31'b0, e.drn});
      chk("req_while_stall", {31'b0, bus.req_fire && bus.issue_stall}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_redir_valid = 1'b0; bus.wb_redir_pc = '0;
    bus.ex_redir_valid = 1'b0; bus.ex_redir_pc = '0;
    bus.id_redir_valid = 1'b0; bus.id_redir_pc = '0;
    bus.req_fire = 1'b0; bus.resp_valid = 1'b0;

    // reset state, then a redirect while in reset: comb outputs live, discard forced low
    n_rst = 1'b1; step(0, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    n_rst = 1'b1; n_exv = 1'b1; n_expc = 32'h1c000050;
    step(0, 1, E(1, 32'h1c000050, 1, 1, 0, 0, 0));

    // stale drain after two requests and an EX redirect
    step(1, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(1, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    n_exv = 1'b1; n_expc = 32'h1c000100;
    step(0, 0, E(1, 32'h1c000100, 1, 1, 0, 0, 0));
    step(0, 1, E(0, 32'h0, 0, 0, 1, 0, 1));
    step(0, 1, E(0, 32'h0, 0, 0, 1, 0, 1));
    step(0, 0, E(0, 32'h0, 0, 0, 0, 0, 0));

    // priority select
    n_wbv = 1'b1; n_wbpc = 32'h1c008000; n_exv = 1'b1; n_expc = 32'h1c000200;
    n_idv = 1'b1; n_idpc = 32'h1c000300;
    step(0, 0, E(1, 32'h1c008000, 1, 1, 0, 0, 0));
    n_exv = 1'b1; n_expc = 32'h1c000200; n_idv = 1'b1; n_idpc = 32'h1c000300;
    step(0, 0, E(1, 32'h1c000200, 1, 1, 0, 0, 0));
    n_idv = 1'b1; n_idpc = 32'h1c000300;
    step(0, 0, E(1, 32'h1c000300, 1, 0, 0, 0, 0));
    n_wbv = 1'b1; n_wbpc = 32'h1c008000; n_idv = 1'b1; n_idpc = 32'h1c000300;
    step(0, 0, E(1, 32'h1c008000, 1, 1, 0, 0, 0));
    step(0, 0, E(0, 32'h0, 0, 0, 0, 0, 0));

    // redirect with same-cycle request and response
    step(1, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    n_exv = 1'b1; n_expc = 32'h1c000400;
    step(1, 1, E(1, 32'h1c000400, 1, 1, 1, 0, 0));
    step(0, 1, E(0, 32'h0, 0, 0, 1, 0, 1));
    step(0, 0, E(0, 32'h0, 0, 0, 0, 0, 0));

    // nested redirect during drain
    step(1, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(1, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    n_idv = 1'b1; n_idpc = 32'h1c000500;
    step(0, 0, E(1, 32'h1c000500, 1, 0, 0, 0, 0));
    step(1, 0, E(0, 32'h0, 0, 0, 0, 0, 1));
    n_exv = 1'b1; n_expc = 32'h1c000600;
    step(0, 0, E(1, 32'h1c000600, 1, 1, 0, 1, 1));
    step(0, 1, E(0, 32'h0, 0, 0, 1, 0, 1));
    step(0, 1, E(0, 32'h0, 0, 0, 1, 0, 1));
    step(0, 1, E(0, 32'h0, 0, 0, 1, 0, 1));
    // spurious response with nothing in flight: kept, and no underflow
    step(0, 1, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(1, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(0, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(0, 1, E(0, 32'h0, 0, 0, 0, 0, 0));

    // stall at the in-flight limit
    step(1, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(1, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(1, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(0, 0, E(0, 32'h0, 0, 0, 0, 1, 0));
    step(0, 1, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(0, 1, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(0, 1, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(0, 0, E(0, 32'h0, 0, 0, 0, 0, 0));

    // reset in the middle of a drain
    step(1, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(1, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    n_exv = 1'b1; n_expc = 32'h1c000700;
    step(0, 0, E(1, 32'h1c000700, 1, 1, 0, 0, 0));
    step(0, 0, E(0, 32'h0, 0, 0, 0, 0, 1));
    n_rst = 1'b1;
    step(0, 1, E(0, 32'h0, 0, 0, 0, 0, 1));
    step(0, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(0, 1, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(1, 0, E(0, 32'h0, 0, 0, 0, 0, 0));
    step(0, 1, E(0, 32'h0, 0, 0, 0, 0, 0));

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
